// File: rtl/cmd_script_seq.sv
// cmd_script_seq
// ---------------------------------------------------------------------------
// Host-side command script sequencer sitting in front of RemoteComm. A small
// script memory is loaded while idle; on start the entries are launched in
// order. Each launch is one send_cmd pulse, then the sequencer waits for
// cmd_sent and resp_rdy, consumes the response with clr_resp_rdy and checks it
// against ACK 8'hA5. The first failing entry (NACK, TIMEOUT or ABORT) is
// reported through err/err_idx/err_code and the script stops.
//
// Optional feature macro: CMD_SEQ_RETRY_EN
//   defined   : a NACK or TIMEOUT relaunches the same entry up to MAX_RETRY
//               extra times before the failure is reported.
//   undefined : the first NACK or TIMEOUT fails the script.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   ld_en/ld_addr/
//   ld_cmd/ld_data      script memory write port (idle only)
//   script_len          number of entries to run, sampled at start
//   start, abort        begin script (idle only) / stop running script
//   cmd, data, send_cmd command to RemoteComm with one-cycle launch pulse
//   cmd_sent            RemoteComm finished transmitting
//   resp_rdy, resp      response byte from RemoteComm
//   clr_resp_rdy        one-cycle response consume pulse
//   busy, done          script running / one-cycle completion pulse
//   err, err_idx,
//   err_code            sticky failure flag, failing entry, 01 NACK 10 TIMEOUT 11 ABORT
// ---------------------------------------------------------------------------
module cmd_script_seq #(
  parameter int unsigned  DEPTH        = 16,
  localparam int unsigned AW           = $clog2(DEPTH),
  parameter logic [23:0]  RESP_TIMEOUT = 24'd2_000_000,
  parameter int unsigned  MAX_RETRY    = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ld_en,
  input  logic [AW-1:0] ld_addr,
  input  logic [7:0]    ld_cmd,
  input  logic [15:0]   ld_data,
  input  logic [AW:0]   script_len,
  input  logic          start,
  input  logic          abort,
  output logic [7:0]    cmd,
  output logic [15:0]   data,
  output logic          send_cmd,
  input  logic          cmd_sent,
  input  logic          resp_rdy,
  input  logic [7:0]    resp,
  output logic          clr_resp_rdy,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [AW-1:0] err_idx,
  output logic [1:0]    err_code
);

  localparam logic [7:0]  ACK        = 8'hA5;
  localparam logic [1:0]  EC_NACK    = 2'b01;
  localparam logic [1:0]  EC_TIMEOUT = 2'b10;
  localparam logic [1:0]  EC_ABORT   = 2'b11;
  localparam logic [AW:0] DEPTH_L    = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_L      = (AW+1)'(1);
  localparam logic [23:0] TMO_LAST   = RESP_TIMEOUT - 24'd1;
  localparam logic [23:0] TMO_SAT    = 24'hFF_FFFF;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SEND      = 3'd1,
    WAIT_SENT = 3'd2,
    WAIT_RESP = 3'd3,
    CHECK     = 3'd4,
    FINISH    = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [AW:0]   idx_q, idx_d;
  logic [AW:0]   len_q, len_d;
  logic [23:0]   timer_q, timer_d;
  logic [7:0]    resp_q, resp_d;
  logic [7:0]    cmd_q, cmd_d;
  logic [15:0]   data_q, data_d;
  logic          send_cmd_q, send_cmd_d;
  logic          clr_q, clr_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [AW-1:0] err_idx_q, err_idx_d;
  logic [1:0]    err_code_q, err_code_d;
  logic          fail_s;
  logic [1:0]    fail_code_s;
  logic [23:0]   rd_entry_s;

  // Script memory: {opcode, data}; deliberately not cleared by rst so a
  // loaded script survives a reset of the sequencer.
  logic [23:0] mem [DEPTH];

`ifdef CMD_SEQ_RETRY_EN
  logic [7:0] retry_q, retry_d;
`else
  // The retry limit has no meaning when the retry path is not built.
  logic unused_retry_cfg;
  assign unused_retry_cfg = (MAX_RETRY != 32'd0);
`endif

  // Script memory write port, open only while idle.
  always_ff @(posedge clk) begin
    if (ld_en && (state_q == IDLE)) begin
      mem[ld_addr] <= {ld_cmd, ld_data};
    end
  end

  assign rd_entry_s = mem[idx_d[AW-1:0]];

  // Next-state, bookkeeping and next-output computation.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    len_d       = len_q;
    timer_d     = timer_q;
    resp_d      = resp_q;
    err_d       = err_q;
    err_idx_d   = err_idx_q;
    err_code_d  = err_code_q;
    fail_s      = 1'b0;
    fail_code_s = 2'b00;
`ifdef CMD_SEQ_RETRY_EN
    retry_d     = retry_q;
`endif

    case (state_q)
      IDLE: begin
        // start together with abort is treated as no start at all
        if (start && !abort) begin
          err_d      = 1'b0;
          err_idx_d  = '0;
          err_code_d = 2'b00;
          idx_d      = '0;
          len_d      = (script_len > DEPTH_L) ? DEPTH_L : script_len;
          if (script_len == '0) begin
            state_d = FINISH;
          end else begin
            state_d = SEND;
          end
        end else begin
          state_d = IDLE;
        end
      end
      SEND: begin
        state_d = WAIT_SENT;
      end
      WAIT_SENT: begin
        if (cmd_sent) begin
          state_d = WAIT_RESP;
        end else begin
          state_d = WAIT_SENT;
        end
      end
      WAIT_RESP: begin
        // a response arriving on the timeout cycle still counts
        if (resp_rdy) begin
          resp_d  = resp;
          state_d = CHECK;
        end else if (timer_q >= TMO_LAST) begin
          fail_s      = 1'b1;
          fail_code_s = EC_TIMEOUT;
        end else begin
          state_d = WAIT_RESP;
        end
      end
      CHECK: begin
        if (resp_q == ACK) begin
          idx_d = idx_q + ONE_L;
          if ((idx_q + ONE_L) == len_q) begin
            state_d = FINISH;
          end else begin
            state_d = SEND;
          end
        end else begin
          fail_s      = 1'b1;
          fail_code_s = EC_NACK;
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Resolve a NACK/TIMEOUT: relaunch the same entry or report it.
    if (fail_s) begin
`ifdef CMD_SEQ_RETRY_EN
      if ({24'd0, retry_q} < MAX_RETRY) begin
        retry_d = retry_q + 8'd1;
        state_d = SEND;
      end else begin
        err_d      = 1'b1;
        err_idx_d  = idx_q[AW-1:0];
        err_code_d = fail_code_s;
        state_d    = FINISH;
      end
`else
      err_d      = 1'b1;
      err_idx_d  = idx_q[AW-1:0];
      err_code_d = fail_code_s;
      state_d    = FINISH;
`endif
    end else begin
      err_d = err_d;
    end

    // Abort overrides everything while running. FINISH is already on its
    // way out, so an abort there would only produce a second done pulse.
    if (abort && (state_q != IDLE) && (state_q != FINISH)) begin
      state_d    = FINISH;
      err_d      = 1'b1;
      err_idx_d  = idx_q[AW-1:0];
      err_code_d = EC_ABORT;
    end else begin
      state_d = state_d;
    end

`ifdef CMD_SEQ_RETRY_EN
    // Each entry gets a fresh retry budget.
    if ((state_q == IDLE) || (idx_d != idx_q)) begin
      retry_d = 8'd0;
    end else begin
      retry_d = retry_d;
    end
`endif

    // Timer is zero in the launch cycle and counts until the response.
    if (state_d == SEND) begin
      timer_d = 24'd0;
    end else if (((state_q == SEND) || (state_q == WAIT_SENT) || (state_q == WAIT_RESP))
                 && (timer_q != TMO_SAT)) begin
      timer_d = timer_q + 24'd1;
    end else begin
      timer_d = timer_q;
    end

    // Outputs are registered, so they are derived from the next state.
    send_cmd_d = (state_d == SEND);
    clr_d      = (state_d == CHECK);
    busy_d     = (state_d != IDLE);
    done_d     = (state_d == FINISH);
    if (state_d == SEND) begin
      cmd_d  = rd_entry_s[23:16];
      data_d = rd_entry_s[15:0];
    end else begin
      cmd_d  = cmd_q;
      data_d = data_q;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      len_q      <= '0;
      timer_q    <= 24'd0;
      resp_q     <= 8'd0;
      cmd_q      <= 8'd0;
      data_q     <= 16'd0;
      send_cmd_q <= 1'b0;
      clr_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_idx_q  <= '0;
      err_code_q <= 2'b00;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      len_q      <= len_d;
      timer_q    <= timer_d;
      resp_q     <= resp_d;
      cmd_q      <= cmd_d;
      data_q     <= data_d;
      send_cmd_q <= send_cmd_d;
      clr_q      <= clr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      err_idx_q  <= err_idx_d;
      err_code_q <= err_code_d;
    end
  end

`ifdef CMD_SEQ_RETRY_EN
  // Retry counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      retry_q <= 8'd0;
    end else begin
      retry_q <= retry_d;
    end
  end
`endif

  assign cmd          = cmd_q;
  assign data         = data_q;
  assign send_cmd     = send_cmd_q;
  assign clr_resp_rdy = clr_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err          = err_q;
  assign err_idx      = err_idx_q;
  assign err_code     = err_code_q;

endmodule

// File: tb/tb_cmd_script_seq.sv
`timescale 1ns/1ps
// Directed testbench for cmd_script_seq (RESP_TIMEOUT overridden to 100).
module tb_cmd_script_seq;

`ifdef CMD_SEQ_RETRY_EN
  localparam int ATTEMPTS = 3;
`else
  localparam int ATTEMPTS = 1;
`endif
  localparam logic [7:0]  EXP_CMD  [3] = '{8'h06, 8'h05, 8'h07};
  localparam logic [15:0] EXP_DATA [3] = '{16'h0000, 16'h00FF, 16'h0000};

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ld_en = 1'b0;
  logic [3:0]  ld_addr = 4'd0;
  logic [7:0]  ld_cmd = 8'd0;
  logic [15:0] ld_data = 16'd0;
  logic [4:0]  script_len = 5'd0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [7:0]  cmd;
  logic [15:0] data;
  logic        send_cmd;
  logic        cmd_sent = 1'b0;
  logic        resp_rdy = 1'b0;
  logic [7:0]  resp = 8'd0;
  logic        clr_resp_rdy;
  logic        busy;
  logic        done;
  logic        err;
  logic [3:0]  err_idx;
  logic [1:0]  err_code;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int send_total = 0;

  always #5 clk = ~clk;

  cmd_script_seq #(.DEPTH(16), .RESP_TIMEOUT(24'd100), .MAX_RETRY(2)) dut (
    .clk(clk), .rst(rst), .ld_en(ld_en), .ld_addr(ld_addr), .ld_cmd(ld_cmd),
    .ld_data(ld_data), .script_len(script_len), .start(start), .abort(abort),
    .cmd(cmd), .data(data), .send_cmd(send_cmd), .cmd_sent(cmd_sent),
    .resp_rdy(resp_rdy), .resp(resp), .clr_resp_rdy(clr_resp_rdy), .busy(busy),
    .done(done), .err(err), .err_idx(err_idx), .err_code(err_code)
  );

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (send_cmd === 1'b1) send_total <= send_total + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: got no $finish, expected end of tests");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_entry(input logic [3:0] a, input logic [7:0] c, input logic [15:0] d);
    ld_en = 1'b1; ld_addr = a; ld_cmd = c; ld_data = d;
    tick();
    ld_en = 1'b0;
  endtask

  task automatic start_script(input logic [4:0] len);
    script_len = len; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_send(output bit ok);
    for (int i = 0; i < 20; i++) begin
      if (send_cmd === 1'b1) break;
      tick();
    end
    ok = (send_cmd === 1'b1);
  endtask

  // Plays RemoteComm for one launch; returns with the DUT in CHECK.
  task automatic serve(input logic [7:0] rsp, input int rdelay, output bit ok,
                       output logic [7:0] c, output logic [15:0] d);
    wait_send(ok);
    c = cmd; d = data;
    tick();
    cmd_sent = 1'b1;
    tick();
    cmd_sent = 1'b0;
    repeat (rdelay) tick();
    resp = rsp; resp_rdy = 1'b1;
    tick();
    resp_rdy = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    checks++;
    if ({cmd, data, send_cmd, clr_resp_rdy, busy, done, err, err_idx, err_code} !== 35'd0)
      begin failures++; $display("FAIL reset_outputs: got %h expected 0",
        {cmd, data, send_cmd, clr_resp_rdy, busy, done, err, err_idx, err_code}); end
    load_entry(4'd0, 8'h06, 16'h0000);
    load_entry(4'd1, 8'h05, 16'h00FF);
    load_entry(4'd2, 8'h07, 16'h0000);
    checks++;
    if (busy !== 1'b0 || send_cmd !== 1'b0) begin failures++;
      $display("FAIL load_idle: got busy=%b send=%b expected 0 0", busy, send_cmd); end
  endtask

  task automatic test_script_ok();
    bit ok; logic [7:0] c; logic [15:0] d; int base;
    base = send_total;
    start_script(5'd3);
    checks++;
    if (send_cmd !== 1'b1 || busy !== 1'b1) begin failures++;
      $display("FAIL start_latency: got send=%b busy=%b expected 1 1", send_cmd, busy); end
    for (int i = 0; i < 3; i++) begin
      serve(8'hA5, 2, ok, c, d);
      checks++;
      if (!ok || c !== EXP_CMD[i] || d !== EXP_DATA[i]) begin failures++;
        $display("FAIL ok_entry%0d: got ok=%0d %h/%h expected %h/%h", i, ok, c, d, EXP_CMD[i], EXP_DATA[i]); end
      checks++;
      if (clr_resp_rdy !== 1'b1) begin failures++;
        $display("FAIL ok_clr%0d: got %b expected 1", i, clr_resp_rdy); end
      tick();
      if (i < 2) begin
        checks++;
        if (send_cmd !== 1'b1) begin failures++;
          $display("FAIL ok_next_send%0d: got %b expected 1", i, send_cmd); end
      end else begin
        checks++;
        if (done !== 1'b1 || err !== 1'b0) begin failures++;
          $display("FAIL ok_done: got done=%b err=%b expected 1 0", done, err); end
      end
    end
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || send_total - base !== 3) begin failures++;
      $display("FAIL ok_end: got busy=%b done=%b sends=%0d expected 0 0 3", busy, done, send_total - base); end
  endtask

  task automatic test_nack();
    bit ok; logic [7:0] c; logic [15:0] d; int base;
    base = send_total;
    start_script(5'd3);
    serve(8'hA5, 1, ok, c, d);
    tick();
    for (int a = 0; a < ATTEMPTS; a++) begin
      serve(8'h5A, 1, ok, c, d);
      checks++;
      if (!ok || c !== 8'h05) begin failures++;
        $display("FAIL nack_send%0d: got ok=%0d cmd=%h expected 1 05", a, ok, c); end
      tick();
      if (a < ATTEMPTS - 1) begin
        checks++;
        if (send_cmd !== 1'b1) begin failures++;
          $display("FAIL nack_retry%0d: got %b expected 1", a, send_cmd); end
      end else begin
        checks++;
        if (done !== 1'b1 || err !== 1'b1 || err_idx !== 4'd1 || err_code !== 2'b01) begin failures++;
          $display("FAIL nack_err: got done=%b err=%b idx=%0d code=%b expected 1 1 1 01", done, err, err_idx, err_code); end
      end
    end
    tick(); tick();
    checks++;
    if (send_total - base !== 1 + ATTEMPTS || err !== 1'b1 || busy !== 1'b0) begin failures++;
      $display("FAIL nack_end: got sends=%0d err=%b busy=%b expected %0d 1 0", send_total - base, err, busy, 1 + ATTEMPTS); end
  endtask

  task automatic test_timeout();
    int es;
    bit ok;
    // no response at all
    start_script(5'd1);
    es = cyc;
    tick(); cmd_sent = 1'b1; tick(); cmd_sent = 1'b0;
    for (int a = 0; a < ATTEMPTS; a++) begin
      for (int i = 0; i < 200; i++) begin
        if (done === 1'b1 || (a < ATTEMPTS - 1 && send_cmd === 1'b1)) break;
        tick();
      end
      checks++;
      if ((cyc - es) !== 100) begin failures++;
        $display("FAIL tmo_latency%0d: got %0d cycles expected 100", a, cyc - es); end
      if (a < ATTEMPTS - 1) begin
        es = cyc;
        tick(); cmd_sent = 1'b1; tick(); cmd_sent = 1'b0;
      end
    end
    checks++;
    if (done !== 1'b1 || err !== 1'b1 || err_code !== 2'b10 || err_idx !== 4'd0) begin failures++;
      $display("FAIL tmo_err: got done=%b err=%b code=%b idx=%0d expected 1 1 10 0", done, err, err_code, err_idx); end
    tick();
    // response on the last allowed cycle
    start_script(5'd1);
    wait_send(ok);
    es = cyc;
    tick(); cmd_sent = 1'b1; tick(); cmd_sent = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (cyc >= es + 99) break;
      tick();
    end
    resp = 8'hA5; resp_rdy = 1'b1;
    tick();
    resp_rdy = 1'b0;
    checks++;
    if (clr_resp_rdy !== 1'b1 || err !== 1'b0) begin failures++;
      $display("FAIL tmo_edge_resp: got clr=%b err=%b expected 1 0", clr_resp_rdy, err); end
    tick();
    checks++;
    if (done !== 1'b1 || err !== 1'b0) begin failures++;
      $display("FAIL tmo_edge_done: got done=%b err=%b expected 1 0", done, err); end
    tick();
  endtask

  task automatic test_abort();
    bit ok; logic [7:0] c; logic [15:0] d; int base;
    start_script(5'd3);
    serve(8'hA5, 0, ok, c, d); tick();
    serve(8'hA5, 0, ok, c, d); tick();
    wait_send(ok);
    tick(); cmd_sent = 1'b1; tick(); cmd_sent = 1'b0; tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if (done !== 1'b1 || err !== 1'b1 || err_code !== 2'b11 || err_idx !== 4'd2) begin failures++;
      $display("FAIL abort_err: got done=%b err=%b code=%b idx=%0d expected 1 1 11 2", done, err, err_code, err_idx); end
    tick();
    base = send_total;
    script_len = 5'd3; start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || send_cmd !== 1'b0) begin failures++;
      $display("FAIL abort_idle: got busy=%b send=%b expected 0 0", busy, send_cmd); end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || err_code !== 2'b11 || send_total !== base) begin failures++;
      $display("FAIL abort_idle2: got done=%b busy=%b code=%b sends=%0d expected 0 0 11 %0d", done, busy, err_code, send_total, base); end
  endtask

  task automatic test_len_zero_and_busy();
    bit ok; logic [7:0] c; logic [15:0] d; int base;
    base = send_total;
    start_script(5'd0);
    checks++;
    if (done !== 1'b1 || send_cmd !== 1'b0 || busy !== 1'b1 || err !== 1'b0) begin failures++;
      $display("FAIL len0: got done=%b send=%b busy=%b err=%b expected 1 0 1 0", done, send_cmd, busy, err); end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || send_total !== base) begin failures++;
      $display("FAIL len0_end: got done=%b busy=%b sends=%0d expected 0 0 %0d", done, busy, send_total, base); end
    resp = 8'hA5; resp_rdy = 1'b1; cmd_sent = 1'b1;
    tick();
    resp_rdy = 1'b0; cmd_sent = 1'b0;
    checks++;
    if (clr_resp_rdy !== 1'b0 || busy !== 1'b0) begin failures++;
      $display("FAIL idle_resp: got clr=%b busy=%b expected 0 0", clr_resp_rdy, busy); end
    base = send_total;
    start_script(5'd1);
    ld_en = 1'b1; ld_addr = 4'd0; ld_cmd = 8'hEE; ld_data = 16'hDEAD;
    script_len = 5'd3; start = 1'b1;
    tick();
    ld_en = 1'b0; start = 1'b0;
    cmd_sent = 1'b1; tick(); cmd_sent = 1'b0;
    resp = 8'hA5; resp_rdy = 1'b1; tick(); resp_rdy = 1'b0;
    tick();
    checks++;
    if (done !== 1'b1 || err !== 1'b0 || send_total - base !== 1) begin failures++;
      $display("FAIL busy_start: got done=%b err=%b sends=%0d expected 1 0 1", done, err, send_total - base); end
    tick();
    start_script(5'd1);
    serve(8'hA5, 0, ok, c, d);
    checks++;
    if (!ok || c !== 8'h06 || d !== 16'h0000) begin failures++;
      $display("FAIL busy_load: got ok=%0d %h/%h expected 06/0000", ok, c, d); end
    tick(); tick();
  endtask

  task automatic test_reset_mid();
    bit ok; logic [7:0] c; logic [15:0] d;
    start_script(5'd3);
    wait_send(ok);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({cmd, data, send_cmd, clr_resp_rdy, busy, done, err, err_idx, err_code} !== 35'd0)
      begin failures++; $display("FAIL rst_mid: got %h expected 0",
        {cmd, data, send_cmd, clr_resp_rdy, busy, done, err, err_idx, err_code}); end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin failures++;
      $display("FAIL rst_mid_done: got done=%b busy=%b expected 0 0", done, busy); end
    start_script(5'd3);
    for (int i = 0; i < 3; i++) begin
      serve(8'hA5, 1, ok, c, d);
      checks++;
      if (!ok || c !== EXP_CMD[i] || d !== EXP_DATA[i]) begin failures++;
        $display("FAIL rerun_entry%0d: got %h/%h expected %h/%h", i, c, d, EXP_CMD[i], EXP_DATA[i]); end
      tick();
    end
    checks++;
    if (done !== 1'b1 || err !== 1'b0) begin failures++;
      $display("FAIL rerun_done: got done=%b err=%b expected 1 0", done, err); end
    tick();
  endtask

  initial begin
    test_reset();
    test_script_ok();
    test_nack();
    test_timeout();
    test_abort();
    test_len_zero_and_busy();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
